// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and configuration helpers for multiplier_iter
// Contents: state_e FSM encoding, width_ok() configuration check, cnt_width() counter sizing.
package multiplier_pkg;

    typedef enum logic [1:0] {
        eIdle = 2'd0,
        eCalc = 2'd1,
        eDone = 2'd2
    } state_e;

    // Legal configuration: at least 2 bits wide and a whole number of digits per operand.
    function automatic bit width_ok(input int width, input int bits_per_iter);
        return (width >= 2) && (bits_per_iter > 0) && ((width % bits_per_iter) == 0);
    endfunction

    // Iteration counter width; a single-iteration build still needs one bit.
    function automatic int cnt_width(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

endpackage

// File: rtl/multiplier_cond_neg.sv
// rtl/multiplier_cond_neg.sv - conditional two's-complement negation
// Ports: value (operand), negate (1 = output -value), result (value or -value, same width).
module multiplier_cond_neg #(
    parameter int width_p = 8
) (
    input  logic [width_p-1:0] value,
    input  logic               negate,
    output logic [width_p-1:0] result
);

    assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/multiplier_iter.sv
// rtl/multiplier_iter.sv - iterative shift-add multiplier, signed or unsigned per operation
// Ports: clk_i/reset_i (async active-high), v_i/ready_o input handshake with a_i, b_i, signed_i;
//        v_o/yumi_i output handshake with c_o (2*width_p-bit product).
module multiplier_iter
    import multiplier_pkg::*;
#(
    parameter int width_p         = 8,
    parameter int bits_per_iter_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    input  logic                   signed_i,
    output logic                   v_o,
    output logic [2*width_p-1:0]   c_o,
    input  logic                   yumi_i
);

    localparam int iters_lp = width_p / bits_per_iter_p;
    localparam int cnt_w_lp = cnt_width(iters_lp);
    localparam int pw_lp    = 2 * width_p;

    if (!width_ok(width_p, bits_per_iter_p)) begin : g_cfg_check
        $error("multiplier_iter: width_p must be >= 2 and divisible by bits_per_iter_p");
    end

    state_e                state_r, state_n;
    logic [width_p-1:0]    a_r, b_r;
    logic [width_p-1:0]    a_mag, b_mag;
    logic [pw_lp-1:0]      acc_r;
    logic [pw_lp-1:0]      pp;
    logic [cnt_w_lp-1:0]   cnt_r;
    logic                  neg_r;
    logic                  accept;
    logic                  last_iter;

    // Operands are stored as magnitudes so the core loop is a plain unsigned
    // shift-add; the sign is reapplied once on the way out.
    multiplier_cond_neg #(.width_p(width_p)) u_a_mag (
        .value  (a_i),
        .negate (signed_i & a_i[width_p-1]),
        .result (a_mag)
    );

    multiplier_cond_neg #(.width_p(width_p)) u_b_mag (
        .value  (b_i),
        .negate (signed_i & b_i[width_p-1]),
        .result (b_mag)
    );

    // Output comes straight from registers, so c_o cannot move while the
    // consumer stalls and clears the instant reset clears acc_r/neg_r.
    multiplier_cond_neg #(.width_p(pw_lp)) u_result (
        .value  (acc_r),
        .negate (neg_r),
        .result (c_o)
    );

    assign accept    = v_i & ready_o;
    assign last_iter = (cnt_r == cnt_w_lp'(iters_lp - 1));

    // One digit of the multiplier times the full multiplicand, placed at the
    // digit's weight within the double-width accumulator.
    always_comb begin
        pp = ({{width_p{1'b0}}, a_r} * pw_lp'(b_r[bits_per_iter_p-1:0]))
             << (int'(cnt_r) * bits_per_iter_p);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_r)
            eIdle: begin
                ready_o = 1'b1;
                if (v_i) state_n = eCalc;
            end
            eCalc: begin
                if (last_iter) state_n = eDone;
            end
            eDone: begin
                v_o = 1'b1;
                if (yumi_i) state_n = eIdle;
            end
            default: state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
            cnt_r <= '0;
            neg_r <= 1'b0;
        end else if (accept) begin
            a_r   <= a_mag;
            b_r   <= b_mag;
            neg_r <= signed_i & (a_i[width_p-1] ^ b_i[width_p-1]);
            acc_r <= '0;
            cnt_r <= '0;
        end else if (state_r == eCalc) begin
            acc_r <= acc_r + pp;
            b_r   <= b_r >> bits_per_iter_p;
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Taking a result that is not being offered is a consumer bug.
    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_multiplier_iter.sv
// tb/tb_multiplier_iter.sv - self-checking bench for multiplier_iter (8x1 and 16x4 builds)
module tb_multiplier_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v8 = 1'b0, s8 = 1'b0, yumi8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, vo8;
    logic [15:0] c8;

    logic        v16 = 1'b0, s16 = 1'b0, yumi16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, vo16;
    logic [31:0] c16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiplier_iter #(.width_p(8), .bits_per_iter_p(1)) dut8 (
        .clk_i(clk), .reset_i(rst), .v_i(v8), .ready_o(ready8), .a_i(a8), .b_i(b8),
        .signed_i(s8), .v_o(vo8), .c_o(c8), .yumi_i(yumi8)
    );

    multiplier_iter #(.width_p(16), .bits_per_iter_p(4)) dut16 (
        .clk_i(clk), .reset_i(rst), .v_i(v16), .ready_o(ready16), .a_i(a16), .b_i(b16),
        .signed_i(s16), .v_o(vo16), .c_o(c16), .yumi_i(yumi16)
    );

    // Reference: exact integer product, operands interpreted per signed mode,
    // reduced to a 2w-bit two's-complement pattern.
    function automatic longint ref_mul(input int w, input longint a, input longint b, input bit s);
        longint one = 1;
        longint x = a;
        longint y = b;
        if (s && (((x >> (w - 1)) & one) == one)) x = x - (one << w);
        if (s && (((y >> (w - 1)) & one) == one)) y = y - (one << w);
        return (x * y) & ((one << (2 * w)) - one);
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        while (!ready8 && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (ready8 !== 1'b1) begin bad++; $display("FAIL issue8_ready got=%b want=1", ready8); end
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    endtask

    task automatic wait_v8(output int lat);
        lat = 0;
        while (!vo8 && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take8();
        yumi8 = 1'b1;
        @(posedge clk); #1;
        yumi8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        while (!ready16 && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (ready16 !== 1'b1) begin bad++; $display("FAIL issue16_ready got=%b want=1", ready16); end
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    endtask

    task automatic wait_v16(output int lat);
        lat = 0;
        while (!vo16 && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take16();
        yumi16 = 1'b1;
        @(posedge clk); #1;
        yumi16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL reset_ready8 got=%b want=1", ready8); end
        total++; if (vo8 !== 1'b0) begin bad++; $display("FAIL reset_v8 got=%b want=0", vo8); end
        total++; if (c8 !== 16'h0) begin bad++; $display("FAIL reset_c8 got=%h want=0000", c8); end
        total++; if (ready16 !== 1'b1) begin bad++; $display("FAIL reset_ready16 got=%b want=1", ready16); end
        total++; if (vo16 !== 1'b0) begin bad++; $display("FAIL reset_v16 got=%b want=0", vo16); end
        total++; if (c16 !== 32'h0) begin bad++; $display("FAIL reset_c16 got=%h want=00000000", c16); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_max();
        int lat;
        issue8(8'hFF, 8'hFF, 1'b0);
        wait_v8(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL umax_latency got=%0d want=8", lat); end
        total++; if (c8 !== 16'hFE01) begin bad++; $display("FAIL umax_c got=%h want=fe01", c8); end
        total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL umax_ready_in_done got=%b want=0", ready8); end
        take8();
        total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL umax_ready_after_yumi got=%b want=1", ready8); end
        total++; if (vo8 !== 1'b0) begin bad++; $display("FAIL umax_v_after_yumi got=%b want=0", vo8); end
    endtask

    task automatic test_signed();
        int lat;
        issue8(8'h80, 8'h80, 1'b1);
        wait_v8(lat);
        total++; if (c8 !== 16'h4000) begin bad++; $display("FAIL signed_min_sq got=%h want=4000", c8); end
        take8();
        issue8(8'hFD, 8'h05, 1'b1);
        wait_v8(lat);
        total++; if (c8 !== 16'hFFF1) begin bad++; $display("FAIL signed_neg15 got=%h want=fff1", c8); end
        take8();
    endtask

    task automatic test_mode_contrast();
        int lat;
        issue8(8'hFD, 8'h05, 1'b0);
        wait_v8(lat);
        total++; if (c8 !== 16'h04F1) begin bad++; $display("FAIL unsigned_fd_x_05 got=%h want=04f1", c8); end
        take8();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] hold;
        issue8(8'h9C, 8'hB7, 1'b1);
        wait_v8(lat);
        hold = 16'(ref_mul(8, longint'(8'h9C), longint'(8'hB7), 1'b1));
        total++; if (c8 !== hold) begin bad++; $display("FAIL bp_result got=%h want=%h", c8, hold); end
        for (int i = 0; i < 20; i++) begin
            v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            @(posedge clk); #1;
            total++; if (vo8 !== 1'b1) begin bad++; $display("FAIL bp_v cyc=%0d got=%b want=1", i, vo8); end
            total++; if (c8 !== hold) begin bad++; $display("FAIL bp_c cyc=%0d got=%h want=%h", i, c8, hold); end
            total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, ready8); end
        end
        v8 = 1'b0;
        take8();
        issue8(8'h12, 8'h34, 1'b0);
        wait_v8(lat);
        total++; if (c8 !== 16'h03A8) begin bad++; $display("FAIL bp_next_op got=%h want=03a8", c8); end
        take8();
    endtask

    task automatic test_reset_mid();
        int lat;
        issue8(8'hFF, 8'hFF, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        #3;
        rst = 1'b1;
        #1;
        total++; if (vo8 !== 1'b0) begin bad++; $display("FAIL midreset_v got=%b want=0", vo8); end
        total++; if (c8 !== 16'h0) begin bad++; $display("FAIL midreset_c got=%h want=0000", c8); end
        total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", ready8); end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        issue8(8'h07, 8'h06, 1'b0);
        wait_v8(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL midreset_latency got=%0d want=8", lat); end
        total++; if (c8 !== 16'h002A) begin bad++; $display("FAIL midreset_next_op got=%h want=002a", c8); end
        take8();
    endtask

    task automatic test_cfg16();
        int lat;
        issue16(16'hFFFF, 16'h0002, 1'b1);
        wait_v16(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL cfg16_latency got=%0d want=4", lat); end
        total++; if (c16 !== 32'hFFFFFFFE) begin bad++; $display("FAIL cfg16_c got=%h want=fffffffe", c16); end
        take16();
        total++; if (ready16 !== 1'b1) begin bad++; $display("FAIL cfg16_ready_after_yumi got=%b want=1", ready16); end
    endtask

    task automatic test_back_to_back8(input int ops);
        int lat;
        logic [7:0] a, b;
        logic s;
        logic [15:0] exp;
        for (int i = 0; i < ops; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            if (i % 16 == 0) a = 8'h80;
            if (i % 16 == 1) b = 8'h00;
            exp = 16'(ref_mul(8, longint'(a), longint'(b), s));
            issue8(a, b, s);
            wait_v8(lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL b2b8_latency op=%0d got=%0d want=8", i, lat); end
            total++; if (c8 !== exp) begin bad++; $display("FAIL b2b8_c op=%0d a=%h b=%h s=%b got=%h want=%h", i, a, b, s, c8, exp); end
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
            take8();
        end
    endtask

    task automatic test_back_to_back16(input int ops);
        int lat;
        logic [15:0] a, b;
        logic s;
        logic [31:0] exp;
        for (int i = 0; i < ops; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            if (i % 16 == 0) begin a = 16'h8000; b = 16'h8000; end
            if (i % 16 == 1) a = 16'hFFFF;
            exp = 32'(ref_mul(16, longint'(a), longint'(b), s));
            issue16(a, b, s);
            wait_v16(lat);
            total++; if (lat !== 4) begin bad++; $display("FAIL b2b16_latency op=%0d got=%0d want=4", i, lat); end
            total++; if (c16 !== exp) begin bad++; $display("FAIL b2b16_c op=%0d a=%h b=%h s=%b got=%h want=%h", i, a, b, s, c16, exp); end
            if ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
            take16();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_mode_contrast();
        test_backpressure();
        test_reset_mid();
        test_cfg16();
        test_back_to_back8(1000);
        test_back_to_back16(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
